// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared state encoding and sizing defaults for the LSTM hidden-memory controller
package lstm_pkg;

    localparam int LSTM_ADDR_WIDTH = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FWD_START = 3'd1,
        ST_FWD_WAIT  = 3'd2,
        ST_FWD_WR    = 3'd3,
        ST_BWD_START = 3'd4,
        ST_BWD_WAIT  = 3'd5,
        ST_DONE      = 3'd6
    } h_state_e;

    // Unit-select width; a single unit still gets one select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/h_step_counter.sv
// rtl/h_step_counter.sv - up/down timestep counter with hidden-memory base address multiply
module h_step_counter
    import lstm_pkg::*;
#(
    parameter int NUM_LSTM   = 2,
    parameter int ADDR_WIDTH = LSTM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  load_one_i,
    input  logic                  inc_i,
    input  logic                  dec_i,
    output logic [ADDR_WIDTH-1:0] t_cnt_o,
    output logic [ADDR_WIDTH-1:0] base_next_o,
    output logic [ADDR_WIDTH-1:0] prev_next_o
);

    localparam logic [ADDR_WIDTH-1:0] UNITS = ADDR_WIDTH'(NUM_LSTM);
    localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] t_q;
    logic [ADDR_WIDTH-1:0] t_d;

    always_comb begin
        t_d = t_q;
        if (clr_i) begin
            t_d = '0;
        end else if (load_one_i) begin
            t_d = ONE;
        end else if (inc_i) begin
            t_d = t_q + ONE;
        end else if (dec_i) begin
            t_d = t_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q <= '0;
        end else begin
            t_q <= t_d;
        end
    end

    // Addresses are derived from the next count so the controller can register them in step with it.
    assign t_cnt_o     = t_q;
    assign base_next_o = t_d * UNITS;
    assign prev_next_o = (t_d - ONE) * UNITS;

endmodule

// File: rtl/memory_h_ctrl.sv
// rtl/memory_h_ctrl.sv - sequences forward cell steps, hidden-state writes and the optional backward pass
module memory_h_ctrl
    import lstm_pkg::*;
#(
    parameter int NUM_LSTM   = 2,
    parameter int TIMESTEP   = 7,
    parameter int ADDR_WIDTH = LSTM_ADDR_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      bptt_en,
    input  logic                                      cell_done,
    input  logic                                      grad_done,
    output logic                                      cell_start,
    output logic                                      grad_start,
    output logic                                      wr,
    output logic [ADDR_WIDTH-1:0]                     wr_addr,
    output logic [ADDR_WIDTH-1:0]                     rd_addr,
    output logic [lstm_pkg::sel_width(NUM_LSTM)-1:0]  wr_sel,
    output logic [ADDR_WIDTH-1:0]                     t_cnt,
    output logic                                      busy,
    output logic                                      done
);

    localparam int                    SEL_W  = sel_width(NUM_LSTM);
    localparam logic [SEL_W-1:0]      LAST_K = SEL_W'(NUM_LSTM - 1);
    localparam logic [ADDR_WIDTH-1:0] T_LAST = ADDR_WIDTH'(TIMESTEP);
    localparam logic [ADDR_WIDTH-1:0] T_ONE  = ADDR_WIDTH'(1);

    generate
        if (NUM_LSTM * (TIMESTEP + 1) > (1 << ADDR_WIDTH)) begin : g_addr_check
            $error("memory_h_ctrl: NUM_LSTM*(TIMESTEP+1) exceeds the ADDR_WIDTH address space");
        end
    endgenerate

    h_state_e              state_q;
    logic                  bptt_q;
    logic                  cell_start_q;
    logic                  grad_start_q;
    logic                  wr_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [SEL_W-1:0]      wr_sel_q;

    logic                  cnt_clr;
    logic                  cnt_load;
    logic                  cnt_inc;
    logic                  cnt_dec;
    logic [ADDR_WIDTH-1:0] t_cnt_w;
    logic [ADDR_WIDTH-1:0] base_next;
    logic [ADDR_WIDTH-1:0] prev_next;
    logic                  last_k;

    // wr_sel doubles as the unit index k within a write burst.
    assign last_k = (wr_sel_q == LAST_K);

    always_comb begin
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE:     cnt_load = start;
            ST_FWD_WR:   cnt_inc  = last_k && (t_cnt_w < T_LAST);
            ST_BWD_WAIT: cnt_dec  = grad_done && (t_cnt_w != T_ONE);
            ST_DONE:     cnt_clr  = 1'b1;
            default:     cnt_clr  = 1'b0;
        endcase
    end

    h_step_counter #(
        .NUM_LSTM   (NUM_LSTM),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_step (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (cnt_clr),
        .load_one_i  (cnt_load),
        .inc_i       (cnt_inc),
        .dec_i       (cnt_dec),
        .t_cnt_o     (t_cnt_w),
        .base_next_o (base_next),
        .prev_next_o (prev_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bptt_q       <= 1'b0;
            cell_start_q <= 1'b0;
            grad_start_q <= 1'b0;
            wr_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_sel_q     <= '0;
        end else begin
            cell_start_q <= 1'b0;
            grad_start_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_FWD_START;
                        bptt_q       <= bptt_en;
                        busy_q       <= 1'b1;
                        cell_start_q <= 1'b1;
                        rd_addr_q    <= prev_next;
                    end
                end
                ST_FWD_START: begin
                    state_q <= ST_FWD_WAIT;
                end
                ST_FWD_WAIT: begin
                    if (cell_done) begin
                        state_q   <= ST_FWD_WR;
                        wr_q      <= 1'b1;
                        wr_sel_q  <= '0;
                        wr_addr_q <= base_next;
                    end
                end
                ST_FWD_WR: begin
                    if (last_k) begin
                        wr_q     <= 1'b0;
                        wr_sel_q <= '0;
                        if (cnt_inc) begin
                            state_q      <= ST_FWD_START;
                            cell_start_q <= 1'b1;
                            rd_addr_q    <= prev_next;
                        end else if (bptt_q) begin
                            state_q      <= ST_BWD_START;
                            grad_start_q <= 1'b1;
                            rd_addr_q    <= base_next;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        wr_sel_q  <= wr_sel_q + SEL_W'(1);
                        wr_addr_q <= wr_addr_q + T_ONE;
                    end
                end
                ST_BWD_START: begin
                    state_q <= ST_BWD_WAIT;
                end
                ST_BWD_WAIT: begin
                    if (grad_done) begin
                        if (cnt_dec) begin
                            state_q      <= ST_BWD_START;
                            grad_start_q <= 1'b1;
                            rd_addr_q    <= base_next;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    bptt_q    <= 1'b0;
                    rd_addr_q <= '0;
                    wr_addr_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cell_start = cell_start_q;
    assign grad_start = grad_start_q;
    assign wr         = wr_q;
    assign wr_addr    = wr_addr_q;
    assign rd_addr    = rd_addr_q;
    assign wr_sel     = wr_sel_q;
    assign t_cnt      = t_cnt_w;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/memory_h_ctrl.md
MEMORY_H_CTRL -- requirements
Module: memory_h_ctrl

Interface
REQ-001 SHALL have parameter NUM_LSTM, default 2: LSTM units per layer (hidden values written per timestep).
REQ-002 SHALL have parameter TIMESTEP, default 7: timesteps per sequence.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9: width of the hidden-memory address buses.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: begin one sequence; sampled only in IDLE.
REQ-007 SHALL have port bptt_en, input, 1: run the backward pass after forward; sampled with start.
REQ-008 SHALL have port cell_done, input, 1: LSTM cell outputs valid for the current timestep.
REQ-009 SHALL have port grad_done, input, 1: gradient step for the current timestep complete.
REQ-010 SHALL have port cell_start, output, 1: one-cycle pulse launching a forward cell step.
REQ-011 SHALL have port grad_start, output, 1: one-cycle pulse launching a backward step.
REQ-012 SHALL have port wr, output, 1: hidden-memory write enable.
REQ-013 SHALL have port wr_addr, output, ADDR_WIDTH: hidden-memory write address.
REQ-014 SHALL have port rd_addr, output, ADDR_WIDTH: hidden-memory read base address.
REQ-015 SHALL have port wr_sel, output, clog2(NUM_LSTM) (min 1): selects which unit's h drives the memory data input.
REQ-016 SHALL have port t_cnt, output, ADDR_WIDTH: current timestep index.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at sequence end.

Function
REQ-019 SHALL use memory layout addr = t*NUM_LSTM + k, where t is the timestep and k is the unit; slot t=0 holds the preloaded initial h.
REQ-020 SHALL implement states IDLE, FWD_START, FWD_WAIT, FWD_WR, BWD_START, BWD_WAIT, DONE.
REQ-021 IDLE: on start=1, SHALL go to FWD_START next cycle with t_cnt=1 and bptt_en latched; otherwise SHALL remain in IDLE.
REQ-022 FWD_START: SHALL assert cell_start for exactly 1 cycle, then go to FWD_WAIT.
REQ-023 During FWD_START and FWD_WAIT, rd_addr SHALL equal (t_cnt-1)*NUM_LSTM and SHALL be held stable.
REQ-024 FWD_WAIT: SHALL stay until cell_done=1, then go to FWD_WR.
REQ-025 FWD_WR: SHALL last exactly NUM_LSTM cycles; in cycle k it SHALL drive wr=1, wr_sel=k, wr_addr=t_cnt*NUM_LSTM+k.
REQ-026 After FWD_WR: if t_cnt<TIMESTEP, SHALL increment t_cnt and go to FWD_START; else SHALL go to BWD_START (latched bptt_en=1) or DONE.
REQ-027 BWD_START: SHALL pulse grad_start for 1 cycle, with rd_addr=t_cnt*NUM_LSTM held through BWD_WAIT.
REQ-028 BWD_WAIT: on grad_done, if t_cnt==1 SHALL go to DONE, else SHALL decrement t_cnt and go to BWD_START.
REQ-029 DONE: SHALL pulse done for 1 cycle, then go to IDLE.
REQ-030 start while busy SHALL be ignored; cell_done/grad_done outside their WAIT state SHALL be ignored.
REQ-031 cell_done arriving in the same cycle as cell_start SHALL be ignored.
REQ-032 wr SHALL be 0 in every state except FWD_WR.
REQ-033 Address arithmetic SHALL be ADDR_WIDTH unsigned; NUM_LSTM*(TIMESTEP+1) <= 2^ADDR_WIDTH SHALL be a parameter check.
REQ-034 Forward step latency SHALL be 1 + (FWD_WAIT cycles) + NUM_LSTM.

Reset
REQ-035 rst SHALL force IDLE from any state, including mid-sequence.
REQ-036 On rst, wr, cell_start, grad_start, busy and done SHALL be 0; wr_addr, rd_addr, wr_sel and t_cnt SHALL be 0; the latched bptt_en SHALL be 0.
REQ-037 rst has priority over start in the same cycle.

Structure
REQ-038 State encoding and the ADDR_WIDTH default SHALL live in shared package lstm_pkg.
REQ-039 The up/down timestep counter with address multiply SHALL be sub-module h_step_counter; the FSM SHALL stay in memory_h_ctrl.

Verification (NUM_LSTM=2, TIMESTEP=7)
REQ-040 Scenario: start, bptt_en=0, cell_done 1 cycle after each cell_start -> rd_addr 0,2,..,12; writes to 2,3,4,..,15 with wr_sel 0,1 alternating; done exactly 28 cycles after leaving IDLE.
REQ-041 Scenario: start, bptt_en=1, grad_done 2 cycles after each grad_start -> backward rd_addr 14,12,..,2 with 7 grad_start pulses, then done.
REQ-042 Scenario: start pulsed during FWD_WAIT, and cell_done pulsed while in FWD_WR -> both ignored; address sequence unchanged.
REQ-043 Scenario: rst at t_cnt=4 in FWD_WR -> next cycle IDLE, wr=0, all outputs 0; a new start then begins at rd_addr 0.
REQ-044 Scenario: cell_done held high continuously -> exactly one FWD_WR burst per step; no extra writes.
